// File: rtl/mips_mc_control_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: FSM state enum,
// opcode/funct field values, datapath mux selector enums, the ALU-decoder
// operation selector and the ALU control code values driven to the ALU.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    // ALU control codes understood by the shared ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        SRCB_REGB  = 2'd0,
        SRCB_FOUR  = 2'd1,
        SRCB_IMM   = 2'd2,
        SRCB_IMMSH = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'd0,
        PCS_ALUOUT = 2'd1,
        PCS_JUMP   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'd0,
        AOP_SUB   = 2'd1,
        AOP_FUNCT = 2'd2
    } alu_op_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// ---------------------------------------------------------------------------
// mips_mc_control_if
// Bundle between the control unit and the multicycle datapath.
//   master : control unit (consumes op/funct/zero, drives enables and muxes)
//   slave  : datapath side (drives op/funct/zero, consumes controls)
// ---------------------------------------------------------------------------
interface mips_mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic [2:0]       alu_cont;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, funct, zero,
        output alu_cont, alu_src_a, alu_src_b, pc_src, pc_en, iord,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               illegal, retired
    );

    modport slave (
        output op, funct, zero,
        input  alu_cont, alu_src_a, alu_src_b, pc_src, pc_en, iord,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               illegal, retired
    );
endinterface

// File: rtl/mips_mc_control_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control generation.
//   i_alu_op    : add / sub / decode from funct
//   i_funct     : R-type function field
//   o_alu_cont  : ALU control code
//   o_funct_bad : funct not supported (only meaningful for AOP_FUNCT)
// ---------------------------------------------------------------------------
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int W_ALUC = 3
) (
    input  alu_op_t           i_alu_op,
    input  logic [5:0]        i_funct,
    output logic [W_ALUC-1:0] o_alu_cont,
    output logic              o_funct_bad
);
    always_comb begin
        o_alu_cont  = ALU_ADD;
        o_funct_bad = 1'b0;
        case (i_alu_op)
            AOP_SUB: o_alu_cont = ALU_SUB;
            AOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_cont = ALU_ADD;
                    FN_SUB:  o_alu_cont = ALU_SUB;
                    FN_AND:  o_alu_cont = ALU_AND;
                    FN_OR:   o_alu_cont = ALU_OR;
                    FN_SLT:  o_alu_cont = ALU_SLT;
                    default: o_funct_bad = 1'b1;   // falls back to ADD
                endcase
            end
            default: o_alu_cont = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mips_mc_control.sv
// ---------------------------------------------------------------------------
// mips_mc_control
// Multicycle MIPS control unit (Moore FSM). Sequences each instruction
// through FETCH/DECODE/... and drives the datapath enables and muxes.
//   clk   : clock
//   rst_n : synchronous active-low reset; also gates all write enables and
//           the illegal pulse to 0 combinationally while low
//   bus   : master side of mips_mc_control_if (op/funct/zero in, controls,
//           illegal pulse and retired-instruction count out)
// ---------------------------------------------------------------------------
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int W_ALUC = 3,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_mc_control_if.master  bus
);
    state_t             r_state;
    logic               r_funct_bad;
    logic [CNT_W-1:0]   r_retired;

    state_t             w_next;
    alu_op_t            w_alu_op;
    logic [W_ALUC-1:0]  w_alu_cont;
    logic               w_funct_bad;
    logic               w_op_ok;
    logic               w_completing;
    alu_src_b_t         w_src_b;
    pc_src_t            w_pc_src;
    logic               w_src_a, w_pc_en, w_iord, w_mem_write, w_ir_write;
    logic               w_reg_dst, w_mem_to_reg, w_reg_write, w_illegal;

    alu_decoder #(.W_ALUC(W_ALUC)) u_alu_decoder (
        .i_alu_op    (w_alu_op),
        .i_funct     (bus.funct),
        .o_alu_cont  (w_alu_cont),
        .o_funct_bad (w_funct_bad)
    );

    assign w_op_ok = (bus.op == OP_LW)   || (bus.op == OP_SW)  ||
                     (bus.op == OP_RTYPE)|| (bus.op == OP_BEQ) ||
                     (bus.op == OP_BNE)  || (bus.op == OP_ADDI)||
                     (bus.op == OP_J);

    // States whose exit into FETCH retires an instruction
    assign w_completing = (r_state == S_MEMWB)  || (r_state == S_MEMWR)  ||
                          (r_state == S_ALUWB)  || (r_state == S_BRANCH) ||
                          (r_state == S_ADDIWB) || (r_state == S_JUMP);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_RTYPE:       w_next = S_EXEC;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_ADDI:        w_next = S_ADDIEX;
                    OP_J:           w_next = S_JUMP;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_retired   <= '0;
            r_funct_bad <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_completing)
                r_retired <= r_retired + CNT_W'(1);
            // IR is stable through ALUWB, so the EXEC-cycle verdict holds
            if (r_state == S_EXEC)
                r_funct_bad <= w_funct_bad;
        end
    end

    always_comb begin
        w_alu_op     = AOP_ADD;
        w_src_a      = 1'b0;
        w_src_b      = SRCB_REGB;
        w_pc_src     = PCS_ALU;
        w_pc_en      = 1'b0;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_src_b    = SRCB_FOUR;
                w_pc_en    = 1'b1;
            end
            S_DECODE: begin
                w_src_b   = SRCB_IMMSH;        // branch target into ALUOut
                w_illegal = !w_op_ok;
            end
            S_MEMADR, S_ADDIEX: begin
                w_src_a = 1'b1;
                w_src_b = SRCB_IMM;
            end
            S_MEMRD:  w_iord = 1'b1;
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXEC: begin
                w_src_a  = 1'b1;
                w_alu_op = AOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = !r_funct_bad;
                w_illegal   = r_funct_bad;
            end
            S_BRANCH: begin
                w_src_a  = 1'b1;
                w_alu_op = AOP_SUB;
                w_pc_src = PCS_ALUOUT;
                // zero arrives in the same cycle; bne takes on non-equal
                w_pc_en  = bus.zero ^ (bus.op == OP_BNE);
            end
            S_ADDIWB: w_reg_write = 1'b1;
            S_JUMP: begin
                w_pc_src = PCS_JUMP;
                w_pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.alu_cont   = w_alu_cont;
    assign bus.alu_src_a  = w_src_a;
    assign bus.alu_src_b  = w_src_b;
    assign bus.pc_src     = w_pc_src;
    assign bus.iord       = w_iord;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.pc_en      = w_pc_en     & rst_n;
    assign bus.mem_write  = w_mem_write & rst_n;
    assign bus.ir_write   = w_ir_write  & rst_n;
    assign bus.reg_write  = w_reg_write & rst_n;
    assign bus.illegal    = w_illegal   & rst_n;
    assign bus.retired    = r_retired;
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS control unit: the initiator side of the ALU control interface.
- Sequences each instruction through a Moore FSM and drives the multicycle datapath enables and muxes.
- Generates the 3-bit ALU control code each cycle and consumes the ALU zero flag to resolve branches.
- Sits between the instruction register (op/funct) and the shared datapath: one ALU, one unified memory, register file.

Parameters:
- W_ALUC, 3, width of ALU control code; fixed by the ALU interface.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- op  in  6  instruction opcode from IR
- funct  in  6  R-type function field from IR
- zero  in  1  ALU zero flag, same cycle as alu_cont
- alu_cont  out  3  ALU control code; ALU_* encodings from common.svh
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- pc_en  out  1  PC write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse on unsupported op or funct
- retired  out  CNT_W  count of completed instructions

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset: rst_n low at a clock edge sets state to FETCH and retired to 0.
  - While rst_n is low, all enables (pc_en, mem_write, ir_write, reg_write) and illegal are forced to 0 combinationally.
  - Reset mid-instruction abandons the instruction with no further writes.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=1, alu_cont=ALU_ADD, pc_src=0, pc_en=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_cont=ALU_ADD (branch target into ALUOut). Next state by op:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq or 000101 bne -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - any other op -> FETCH, illegal=1 this cycle, retired unchanged.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_cont=ALU_ADD. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR: iord=1, mem_write=1 -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_cont decoded from funct -> ALUWB.
  - 100000 ALU_ADD; 100010 ALU_SUB; 100100 ALU_AND; 100101 ALU_OR; 101010 ALU_SLT.
  - Any other funct: ALU_ADD, with the invalid flag captured into a register.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 unless funct was invalid. If invalid: reg_write=0 and illegal=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_cont=ALU_SUB, pc_src=1.
  - pc_en = zero for beq, ~zero for bne; evaluated in the same cycle. Next is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_cont=ALU_ADD -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP: pc_src=2, pc_en=1 -> FETCH.
- Unlisted outputs are 0 in every state; alu_cont defaults to ALU_ADD.
- Latency in cycles: lw 5; sw, R-type, addi 4; beq, bne, j 3.
- retired: increments by 1 on each transition into FETCH from a completing state (MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP). Taken and not-taken branches both count. Wraps modulo 2^CNT_W.
- op and funct are sampled combinationally; the IR holds them stable from DECODE onward.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - state enum
  - opcode and funct localparams
  - alu_src_b and pc_src enums
- ALU_* codes stay in common.svh and are used directly.
- Sub-module `alu_decoder`: combinational (alu_op[1:0], funct) -> (alu_cont, funct_bad).
  - alu_op: 0 = add, 1 = sub, 2 = use funct.
  - The FSM drives alu_op per state.

Test Plan:
- lw (op=100011) from reset → states FETCH→DECODE→MEMADR→MEMRD→MEMWB; reg_write=1 only in cycle 5 with mem_to_reg=1; retired goes 0→1.
- R-type with funct=101010 → alu_cont=ALU_SLT in EXEC, reg_write=1 with reg_dst=1 in ALUWB; funct=100010 gives ALU_SUB.
- beq with zero=1 in BRANCH → pc_en=1, pc_src=1; repeat with zero=0 → pc_en=0; bne inverted; retired +1 in every case.
- op=111111 → illegal pulses 1 cycle in DECODE, FETCH next, retired unchanged, no reg_write or mem_write.
- R-type with funct=000111 → reg_write=0 and illegal=1 in ALUWB.
- rst_n low during MEMWR of sw → mem_write=0 that cycle, state is FETCH after the edge, retired=0; j after reset gives pc_src=2, pc_en=1 in cycle 3.
